operand_fetch: RTL

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch_pkg.sv | 22 ++
 rtl/operand_fetch_scoreboard.sv | 60 ++++++
 rtl/operand_fetch.sv | 107 ++++++++++
 3 files changed

// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: widths and operand-bundle layout shared by the
// operand fetch stage, the register file and the execute stage.
//   DATAW        operand / writeback data width
//   NREGS, REGW  architectural register count and index width
//   of_bundle_t  operand bundle handed from fetch to execute
package operand_fetch_pkg;

    localparam int DATAW = 32;
    localparam int NREGS = 8;
    localparam int REGW  = $clog2(NREGS);

    typedef logic [REGW-1:0]  reg_idx_t;
    typedef logic [DATAW-1:0] data_t;

    typedef struct packed {
        data_t    a;    // source operand 1
        data_t    b;    // source operand 2
        reg_idx_t dst;  // destination register
        logic     wb;   // instruction writes dst
    } of_bundle_t;

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// of_scoreboard: one busy bit per architectural register, tracking
// writes that have issued but not yet written back.
//   clk, rst            clock, synchronous active-high reset
//   src1_i, src2_i      source indices of the candidate instruction
//   dst_i, wb_i         destination index and write flag of the candidate
//   issue_i             candidate is accepted this cycle
//   we_i, w_i           snooped regfile writeback enable / index
//   hazard_o            candidate must stall (RAW on a source or WAW on dst)
//   busy_o              current busy bits
module of_scoreboard
    import operand_fetch_pkg::*;
#(
    parameter int NREGS = operand_fetch_pkg::NREGS,
    parameter int REGW  = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REGW-1:0]  src1_i,
    input  logic [REGW-1:0]  src2_i,
    input  logic [REGW-1:0]  dst_i,
    input  logic             wb_i,
    input  logic             issue_i,
    input  logic             we_i,
    input  logic [REGW-1:0]  w_i,
    output logic             hazard_o,
    output logic [NREGS-1:0] busy_o
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic             rdy1, rdy2, waw;

    // A source whose value is arriving on the write port this cycle is
    // usable through the bypass, so it does not stall.
    assign rdy1 = !busy_q[src1_i] || (we_i && (w_i == src1_i));
    assign rdy2 = !busy_q[src2_i] || (we_i && (w_i == src2_i));
    // WAW looks only at the registered bit: a same-cycle writeback of dst
    // still stalls, so the older write cannot clear the newer busy bit.
    assign waw  = wb_i && busy_q[dst_i];

    assign hazard_o = !rdy1 || !rdy2 || waw;
    assign busy_o   = busy_q;

    // Clear first, then set, so a set wins when both hit one register.
    // Clearing an already-idle bit is harmless.
    always_comb begin
        busy_d = busy_q;
        if (we_i)
            busy_d[w_i] = 1'b0;
        if (issue_i && wb_i)
            busy_d[dst_i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: reads source operands (with writeback bypass), stalls on
// register hazards via of_scoreboard, and holds one operand bundle in an
// output register with a valid/ready handshake.
//   clk, rst                 clock, synchronous active-high reset
//   iv, iready               upstream instruction handshake
//   isrc1, isrc2, idst, iwb  instruction register fields
//   r1, r2 / out1, out2      regfile read address / combinational read data
//   in, w, we                snooped regfile write port
//   ov, oready               downstream bundle handshake
//   oa, ob, odst, owb        registered operand bundle
//   stallcnt                 saturating count of hazard-stall cycles
// DATAW and NREGS must match operand_fetch_pkg, whose bundle layout is used.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int DATAW = operand_fetch_pkg::DATAW,
    parameter int NREGS = operand_fetch_pkg::NREGS,
    parameter int REGW  = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iv,
    output logic             iready,
    input  logic [REGW-1:0]  isrc1,
    input  logic [REGW-1:0]  isrc2,
    input  logic [REGW-1:0]  idst,
    input  logic             iwb,
    output logic [REGW-1:0]  r1,
    output logic [REGW-1:0]  r2,
    input  logic [DATAW-1:0] out1,
    input  logic [DATAW-1:0] out2,
    input  logic [DATAW-1:0] in,
    input  logic [REGW-1:0]  w,
    input  logic             we,
    output logic             ov,
    input  logic             oready,
    output logic [DATAW-1:0] oa,
    output logic [DATAW-1:0] ob,
    output logic [REGW-1:0]  odst,
    output logic             owb,
    output logic [15:0]      stallcnt
);

    logic             hazard, accept;
    logic [NREGS-1:0] busy;
    of_bundle_t       bundle_q, bundle_d;
    logic             ov_q, ov_d;
    logic [15:0]      stall_q, stall_d;

    assign r1 = isrc1;
    assign r2 = isrc2;

    of_scoreboard #(.NREGS(NREGS), .REGW(REGW)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .src1_i   (isrc1),
        .src2_i   (isrc2),
        .dst_i    (idst),
        .wb_i     (iwb),
        .issue_i  (accept),
        .we_i     (we),
        .w_i      (w),
        .hazard_o (hazard),
        .busy_o   (busy)
    );

    // Output slot is free when empty or being drained this cycle.
    assign iready = !rst && !hazard && (!ov_q || oready);
    assign accept = iv && iready;

    always_comb begin
        bundle_d = bundle_q;
        ov_d     = ov_q;
        if (accept) begin
            ov_d         = 1'b1;
            bundle_d.a   = (we && (w == isrc1)) ? in : out1;
            bundle_d.b   = (we && (w == isrc2)) ? in : out2;
            bundle_d.dst = idst;
            bundle_d.wb  = iwb;
        end else if (oready) begin
            ov_d = 1'b0;
        end
        stall_d = stall_q;
        if (iv && hazard && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bundle_q <= '0;
            ov_q     <= 1'b0;
            stall_q  <= '0;
        end else begin
            bundle_q <= bundle_d;
            ov_q     <= ov_d;
            stall_q  <= stall_d;
        end
    end

    assign ov       = ov_q;
    assign oa       = bundle_q.a;
    assign ob       = bundle_q.b;
    assign odst     = bundle_q.dst;
    assign owb      = bundle_q.wb;
    assign stallcnt = stall_q;

endmodule
